// File: rtl/sym_vn_lut_loader_if.sv
// ---------------------------------------------------------------------------
// sym_vn_lut_loader_if
//   Word stream carrying LUT entries into sym_vn_lut_loader.
//   A word moves across on a rising edge where lut_word_valid and
//   lut_word_ready are both high.
//
//   Signals:
//     lut_word_in     DATA_W  LUT entry for the loader's current address
//     lut_word_valid  1       lut_word_in holds a valid entry
//     lut_word_ready  1       loader accepts a word this cycle
//
//   Modports:
//     master  - the word source
//     slave   - the loader
// ---------------------------------------------------------------------------
interface sym_vn_lut_loader_if #(
    parameter int DATA_W = 3
);
    logic [DATA_W-1:0] lut_word_in;
    logic              lut_word_valid;
    logic              lut_word_ready;

    modport master (
        output lut_word_in,
        output lut_word_valid,
        input  lut_word_ready
    );

    modport slave (
        input  lut_word_in,
        input  lut_word_valid,
        output lut_word_ready
    );
endinterface

// File: rtl/sym_vn_lut_loader.sv
// ---------------------------------------------------------------------------
// sym_vn_lut_loader
//   Write controller for the symmetric VN rank LUT. It takes a stream of
//   DEPTH entries and writes each one to both LUT replicas, so the two read
//   ports always see the same table. table_valid is raised once a complete
//   load has been written.
//
//   Optional build macro: SYM_VN_LUT_LOAD_CHECKSUM_EN
//     When defined, the loader sums the accepted words. It compares the sum
//     against chk_expected at the end of the load. A mismatch sets chk_err
//     and keeps table_valid low.
//
//   Ports:
//     write_clk        in   clock; all logic is on its rising edge
//     rstn             in   synchronous reset, active-low
//     load_start       in   pulse that begins a full table load
//     load_abort       in   cancels an in-progress load
//     word_bus         if   entry stream (slave side)
//     lut_in_bank0_replicate_0/1     out  write data, replicas 0/1
//     page_write_addr_replicate_0/1  out  write address, replicas 0/1
//     we               out  LUT write enable
//     busy             out  a load is in progress
//     load_done        out  one-cycle pulse when a load completes
//     table_valid      out  LUT holds a complete, consistent table
//     chk_expected     in   expected entry sum (checksum build only)
//     chk_err          out  checksum mismatch (checksum build only)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for load_start
//   LOAD  | accepting words; one register write per accepted word
//   FLUSH | last word's write is on the LUT port; finish on next edge
// ---------------------------------------------------------------------------
module sym_vn_lut_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
) (
    input  logic                       write_clk,
    input  logic                       rstn,
    input  logic                       load_start,
    input  logic                       load_abort,
    sym_vn_lut_loader_if.slave         word_bus,
    output logic [DATA_W-1:0]          lut_in_bank0_replicate_0,
    output logic [ADDR_W-1:0]          page_write_addr_replicate_0,
    output logic [DATA_W-1:0]          lut_in_bank0_replicate_1,
    output logic [ADDR_W-1:0]          page_write_addr_replicate_1,
    output logic                       we,
    output logic                       busy,
    output logic                       load_done,
    output logic                       table_valid,
    input  logic [ADDR_W+DATA_W-1:0]   chk_expected,
    output logic                       chk_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   counter, counter_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                we_q, we_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                tv_q, tv_n;
    logic                accept;
    logic                table_ok;

    assign word_bus.lut_word_ready = (state == LOAD);
    assign accept = word_bus.lut_word_valid && (state == LOAD);

`ifdef SYM_VN_LUT_LOAD_CHECKSUM_EN
    localparam int SUM_W = ADDR_W + DATA_W;

    logic [SUM_W-1:0] sum_q, sum_n;
    logic             chk_err_q, chk_err_n;

    assign table_ok = (sum_q == chk_expected);
    assign chk_err  = chk_err_q;

    always_comb begin
        sum_n     = sum_q;
        chk_err_n = chk_err_q;
        if (accept) begin
            sum_n = sum_q + SUM_W'(word_bus.lut_word_in);
        end
        // An abort during FLUSH is ignored, so the sum must survive it.
        if ((state == IDLE && load_start) || (load_abort && state != FLUSH)) begin
            sum_n = '0;
        end
        if (state == IDLE && load_start && !load_abort) begin
            chk_err_n = 1'b0;
        end
        if (state == FLUSH) begin
            chk_err_n = (sum_q != chk_expected);
        end
    end

    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_n;
            chk_err_q <= chk_err_n;
        end
    end
`else
    logic unused_chk_expected;

    assign unused_chk_expected = ^chk_expected;
    assign table_ok = 1'b1;
    assign chk_err  = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        counter_n = counter;
        data_n    = data_q;
        addr_n    = addr_q;
        we_n      = 1'b0;
        busy_n    = busy_q;
        done_n    = 1'b0;
        tv_n      = tv_q;

        // A word accepted on the same edge as an abort is still written.
        if (accept) begin
            we_n      = 1'b1;
            addr_n    = counter;
            data_n    = word_bus.lut_word_in;
            counter_n = counter + 1'b1;
        end

        case (state)
            IDLE: begin
                if (load_start && !load_abort) begin
                    state_n   = LOAD;
                    counter_n = '0;
                    busy_n    = 1'b1;
                    tv_n      = 1'b0;
                end
            end
            LOAD: begin
                if (load_abort) begin
                    state_n   = IDLE;
                    counter_n = '0;
                    busy_n    = 1'b0;
                end else if (accept && counter == LAST_ADDR) begin
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                state_n   = IDLE;
                counter_n = '0;
                busy_n    = 1'b0;
                done_n    = 1'b1;
                tv_n      = table_ok;
            end
            default: begin
                state_n   = IDLE;
                counter_n = '0;
                busy_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            state   <= IDLE;
            counter <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tv_q    <= 1'b0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
            data_q  <= data_n;
            addr_q  <= addr_n;
            we_q    <= we_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            tv_q    <= tv_n;
        end
    end

    assign lut_in_bank0_replicate_0    = data_q;
    assign lut_in_bank0_replicate_1    = data_q;
    assign page_write_addr_replicate_0 = addr_q;
    assign page_write_addr_replicate_1 = addr_q;
    assign we          = we_q;
    assign busy        = busy_q;
    assign load_done   = done_q;
    assign table_valid = tv_q;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
module tb_sym_vn_lut_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 3;

    logic write_clk = 1'b0;
    logic rstn = 1'b0;
    logic load_start = 1'b0;
    logic load_abort = 1'b0;
    logic [DATA_W-1:0] data0, data1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic we, busy, load_done, table_valid, chk_err;
    logic [ADDR_W+DATA_W-1:0] chk_expected = '0;

    sym_vn_lut_loader_if #(.DATA_W(DATA_W)) bus ();

    sym_vn_lut_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .write_clk                   (write_clk),
        .rstn                        (rstn),
        .load_start                  (load_start),
        .load_abort                  (load_abort),
        .word_bus                    (bus),
        .lut_in_bank0_replicate_0    (data0),
        .page_write_addr_replicate_0 (addr0),
        .lut_in_bank0_replicate_1    (data1),
        .page_write_addr_replicate_1 (addr1),
        .we                          (we),
        .busy                        (busy),
        .load_done                   (load_done),
        .table_valid                 (table_valid),
        .chk_expected                (chk_expected),
        .chk_err                     (chk_err)
    );

    always #5 write_clk = ~write_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t act_q[$];
    int  exp_done[$];
    int  act_done[$];

    // Reference model: a load is "active" from the start edge until DEPTH
    // words have been taken or it is aborted; a completed load finishes one
    // edge after its last word.
    bit m_active = 0;
    bit m_flush = 0;
    bit m_tv = 0;
    bit m_chk_err = 0;
    int m_count = 0;
    int m_sum = 0;

    always @(negedge write_clk) begin
        if (we === 1'b1) begin
            act_q.push_back('{cyc, int'(addr0), int'(data0)});
            total++;
            if (addr1 !== addr0 || data1 !== data0) begin
                bad++;
                $display("FAIL replica_equal: cyc=%0d addr1=%0d addr0=%0d data1=%0d data0=%0d",
                         cyc, addr1, addr0, data1, data0);
            end
        end
        if (load_done === 1'b1) act_done.push_back(cyc);
    end

    task automatic drive(input bit rv, input bit st, input bit ab, input bit v, input int w);
        rstn = rv;
        load_start = st;
        load_abort = ab;
        bus.lut_word_valid = v;
        bus.lut_word_in = w[DATA_W-1:0];
        @(posedge write_clk);
        cyc++;
        if (!rv) begin
            m_active = 0; m_flush = 0; m_tv = 0; m_chk_err = 0; m_count = 0; m_sum = 0;
        end else if (m_flush) begin
            m_flush = 0;
            exp_done.push_back(cyc);
`ifdef SYM_VN_LUT_LOAD_CHECKSUM_EN
            m_chk_err = ((m_sum % 256) != int'(chk_expected));
            m_tv = !m_chk_err;
`else
            m_tv = 1;
`endif
        end else if (m_active) begin
            if (v) begin
                exp_q.push_back('{cyc, m_count, w % 8});
                m_count++;
                m_sum += w % 8;
            end
            if (ab) m_active = 0;
            else if (m_count == DEPTH) begin
                m_active = 0;
                m_flush = 1;
            end
        end else if (st && !ab) begin
            m_active = 1; m_count = 0; m_tv = 0; m_sum = 0; m_chk_err = 0;
        end
        @(negedge write_clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete(); act_q.delete(); exp_done.delete(); act_done.delete();
    endtask

    function automatic int write_diff();
        if (act_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i])
            if (act_q[i].cyc != exp_q[i].cyc || act_q[i].addr != exp_q[i].addr ||
                act_q[i].data != exp_q[i].data) return i;
        return -1;
    endfunction

    function automatic int done_diff();
        if (act_done.size() != exp_done.size()) return -2;
        foreach (exp_done[i]) if (act_done[i] != exp_done[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        total++;
        if ({we, busy, load_done, table_valid, chk_err, bus.lut_word_ready} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {we, busy, load_done, table_valid, chk_err, bus.lut_word_ready});
        end
        total++;
        if ({addr0, addr1, data0, data1} !== '0) begin
            bad++;
            $display("FAIL reset_bus: got %h want 0", {addr0, addr1, data0, data1});
        end
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_full_load();
        int t0, d, n;
        clear_logs();
        drive(1, 1, 0, 1, 0);
        t0 = cyc;
        total++;
        if (busy !== 1'b1 || bus.lut_word_ready !== 1'b1 || table_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_start: busy=%b ready=%b tv=%b want 1 1 0", busy, bus.lut_word_ready, table_valid);
        end
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 1, i % 8);
        total++;
        if (busy !== 1'b1 || load_done !== 1'b0 || we !== 1'b1) begin
            bad++;
            $display("FAIL full_flush: busy=%b done=%b we=%b want 1 0 1", busy, load_done, we);
        end
        drive(1, 0, 0, 0, 0);
        total++;
        if (load_done !== 1'b1 || table_valid !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
            bad++;
            $display("FAIL full_done: done=%b tv=%b busy=%b we=%b want 1 1 0 0", load_done, table_valid, busy, we);
        end
        drive(1, 0, 0, 0, 0);
        total++;
        if (load_done !== 1'b0) begin
            bad++;
            $display("FAIL full_done_pulse: done=%b want 0", load_done);
        end
        n = 0;
        foreach (act_q[i])
            if (act_q[i].addr != i || act_q[i].data != i % 8 || act_q[i].cyc != t0 + 1 + i) n++;
        total++;
        if (act_q.size() != DEPTH || n != 0) begin
            bad++;
            $display("FAIL full_writes: writes=%0d wrong=%0d want %0d and 0", act_q.size(), n, DEPTH);
        end
        total++;
        if (act_done.size() != 1 || act_done[0] != t0 + DEPTH + 1) begin
            bad++;
            $display("FAIL full_done_cycle: count=%0d want 1 at cycle %0d", act_done.size(), t0 + DEPTH + 1);
        end
        d = write_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL full_model: diff at %0d want -1", d);
        end
    endtask

    task automatic test_valid_toggle();
        int k, d, n;
        bit v;
        clear_logs();
        drive(1, 1, 0, 0, 0);
        k = 0;
        while ((m_active || m_flush) && k < 400) begin
            v = (k < 20) ? bit'(k % 2 == 0) : bit'($urandom_range(0, 1));
            drive(1, 0, 0, v, int'($urandom_range(0, 7)));
            k++;
        end
        total++;
        if (k >= 400) begin
            bad++;
            $display("FAIL toggle_timeout: cycles=%0d limit=400", k);
        end
        drive(1, 0, 0, 1, 5);
        n = 0;
        foreach (act_q[i]) if (act_q[i].addr != i) n++;
        total++;
        if (act_q.size() != DEPTH || n != 0) begin
            bad++;
            $display("FAIL toggle_addr_seq: writes=%0d gaps=%0d want %0d and 0", act_q.size(), n, DEPTH);
        end
        d = write_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL toggle_data: diff at %0d want -1", d);
        end
        d = done_diff();
        total++;
        if (d != -1 || table_valid !== 1'b1) begin
            bad++;
            $display("FAIL toggle_done: diff=%0d tv=%b want -1 1", d, table_valid);
        end
    endtask

    task automatic test_abort();
        int d;
        clear_logs();
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive(1, 0, 0, 1, int'($urandom_range(0, 7)));
        drive(1, 0, 1, 1, int'($urandom_range(0, 7)));
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 3);
        d = write_diff();
        total++;
        if (act_q.size() != 10 || d != -1) begin
            bad++;
            $display("FAIL abort_writes: writes=%0d diff=%0d want 10 and -1", act_q.size(), d);
        end
        total++;
        if (act_done.size() != 0 || table_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: dones=%0d tv=%b busy=%b want 0 0 0", act_done.size(), table_valid, busy);
        end
        clear_logs();
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 1, int'($urandom_range(0, 7)));
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        d = write_diff();
        total++;
        if (d != -1 || done_diff() != -1 || table_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_reload: diff=%0d dones=%0d tv=%b want -1 1 1", d, act_done.size(), table_valid);
        end
    endtask

    task automatic test_start_ignored();
        int d;
        clear_logs();
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            drive(1, bit'(i == 5 || i == 20), 0, 1, int'($urandom_range(0, 7)));
        drive(1, 1, 0, 1, 2);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 2);
        d = write_diff();
        total++;
        if (act_q.size() != DEPTH || d != -1) begin
            bad++;
            $display("FAIL restart_writes: writes=%0d diff=%0d want %0d and -1", act_q.size(), d, DEPTH);
        end
        total++;
        if (act_done.size() != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_done: dones=%0d busy=%b want 1 0", act_done.size(), busy);
        end
    endtask

    task automatic test_priority();
        int d;
        clear_logs();
        drive(1, 1, 1, 1, 3);
        drive(1, 0, 0, 1, 3);
        total++;
        if (busy !== 1'b0 || act_q.size() != 0) begin
            bad++;
            $display("FAIL abort_wins: busy=%b writes=%0d want 0 0", busy, act_q.size());
        end
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 1, int'($urandom_range(0, 7)));
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        d = write_diff();
        total++;
        if (d != -1 || act_done.size() != 1 || table_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_abort: diff=%0d dones=%0d tv=%b want -1 1 1", d, act_done.size(), table_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        int d;
        clear_logs();
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 1, int'($urandom_range(0, 7)));
        drive(0, 0, 0, 1, 6);
        total++;
        if ({we, busy, load_done, table_valid, chk_err, addr0, addr1, data0, data1} !== '0) begin
            bad++;
            $display("FAIL midreset_zero: got %h want 0",
                     {we, busy, load_done, table_valid, chk_err, addr0, addr1, data0, data1});
        end
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, int'($urandom_range(0, 7)));
        d = write_diff();
        total++;
        if (act_q.size() != 20 || d != -1 || table_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_writes: writes=%0d diff=%0d tv=%b want 20 -1 0", act_q.size(), d, table_valid);
        end
    endtask

    task automatic test_checksum();
`ifdef SYM_VN_LUT_LOAD_CHECKSUM_EN
        int exp_vals[2] = '{224, 223};
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            chk_expected = 8'(exp_vals[r]);
            drive(1, 1, 0, 0, 0);
            for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 1, 7);
            drive(1, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0);
            total++;
            if (chk_err !== bit'(r == 1) || table_valid !== bit'(r == 0) || act_done.size() != 1) begin
                bad++;
                $display("FAIL checksum_%0d: chk_err=%b tv=%b dones=%0d want %b %b 1",
                         exp_vals[r], chk_err, table_valid, act_done.size(), r == 1, r == 0);
            end
            total++;
            if (chk_err !== m_chk_err || table_valid !== m_tv) begin
                bad++;
                $display("FAIL checksum_model: chk_err=%b tv=%b want %b %b", chk_err, table_valid, m_chk_err, m_tv);
            end
        end
`else
        clear_logs();
        chk_expected = 8'($urandom_range(0, 255));
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 1, int'($urandom_range(0, 7)));
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        total++;
        if (chk_err !== 1'b0 || table_valid !== 1'b1 || act_done.size() != 1) begin
            bad++;
            $display("FAIL checksum_off: chk_err=%b tv=%b dones=%0d want 0 1 1", chk_err, table_valid, act_done.size());
        end
`endif
    endtask

    initial begin
        bus.lut_word_valid = 1'b0;
        bus.lut_word_in = '0;
        @(negedge write_clk);
        test_reset();
        test_full_load();
        test_valid_toggle();
        test_abort();
        test_start_ignored();
        test_priority();
        test_reset_mid_load();
        test_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
